fpu_add_issue_ctrl: RTL and testbench

// Issuer/collector for the single-precision FP adder: the requesting end of its req_in/valid_out interface.

---
 rtl/fpu_pkg.sv | 54 +++++
 rtl/fpu_result_fifo.sv | 59 +++++
 rtl/fpu_add_issue_ctrl.sv | 159 +++++++++++++++
 tb/tb_fpu_add_issue_ctrl.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fpu_pkg.sv
// Shared FP adder definitions: rounding modes, adder exception codes,
// RISC-V fflags bit positions, issue-controller FSM states and helpers.
package fpu_pkg;

  localparam logic [2:0] RM_RNE = 3'b000;
  localparam logic [2:0] RM_RTZ = 3'b001;
  localparam logic [2:0] RM_RDN = 3'b010;
  localparam logic [2:0] RM_RUP = 3'b011;
  localparam logic [2:0] RM_RMM = 3'b100;
  localparam logic [2:0] RM_DYN = 3'b111;

  localparam logic [31:0] QNAN_SP = 32'h7FC0_0000;

  // Exception codes reported by the adder alongside each result
  localparam logic [2:0] EXC_NV   = 3'b100;
  localparam logic [2:0] EXC_DZ   = 3'b011;
  localparam logic [2:0] EXC_OF   = 3'b010;
  localparam logic [2:0] EXC_UF   = 3'b001;
  localparam logic [2:0] EXC_NX   = 3'b000;
  localparam logic [2:0] EXC_NONE = 3'b111;

  // Bit positions inside the 5-bit fflags vector {NV,DZ,OF,UF,NX}
  localparam int FFLAG_NX = 0;
  localparam int FFLAG_UF = 1;
  localparam int FFLAG_OF = 2;
  localparam int FFLAG_DZ = 3;
  localparam int FFLAG_NV = 4;

  // Issue controller FSM encoding
  localparam logic [1:0] ST_RUN   = 2'd0;
  localparam logic [1:0] ST_DRAIN = 2'd1;
  localparam logic [1:0] ST_HOLD  = 2'd2;

  // Overflow and underflow always imply inexact.
  function automatic logic [4:0] exc_to_fflags(input logic [2:0] exc);
    logic [4:0] f;
    f = '0;
    case (exc)
      EXC_NV: f[FFLAG_NV] = 1'b1;
      EXC_DZ: f[FFLAG_DZ] = 1'b1;
      EXC_OF: begin f[FFLAG_OF] = 1'b1; f[FFLAG_NX] = 1'b1; end
      EXC_UF: begin f[FFLAG_UF] = 1'b1; f[FFLAG_NX] = 1'b1; end
      EXC_NX: f[FFLAG_NX] = 1'b1;
      default: f = '0;
    endcase
    return f;
  endfunction

  // Rounding modes 101/110/111 (after dynamic resolution) are reserved.
  function automatic logic rm_is_legal(input logic [2:0] rm);
    return !(rm[2] & (rm[1] | rm[0]));
  endfunction

endpackage

// File: rtl/fpu_result_fifo.sv
// In-order first-word-fall-through result buffer. An entry pushed into an
// empty FIFO is visible at the head in the same cycle, so push and pop may
// coincide at any occupancy, including empty. Head is zero when not valid.
module fpu_result_fifo #(
  parameter int W     = 43,
  parameter int DEPTH = 2,
  parameter int CNT_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [W-1:0]     push_ent,
  input  logic             pop,
  output logic             valid,
  output logic [W-1:0]     head,
  output logic [CNT_W-1:0] count
);
  import fpu_pkg::*;

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W-1:0] LAST = PTR_W'(DEPTH - 1);

  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic             empty;
  logic             do_pop;
  logic             wr_en;
  logic             rd_en;

  // Head selection with same-cycle bypass when empty
  always_comb begin
    empty  = (count == '0);
    valid  = ~empty | push;
    do_pop = pop & valid;
    wr_en  = push & ~(empty & do_pop);
    rd_en  = do_pop & ~empty;
    head   = '0;
    if (valid) head = empty ? push_ent : mem[rd_ptr];
  end

  // Storage, pointers and occupancy
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) begin
        mem[wr_ptr] <= push_ent;
        wr_ptr      <= (wr_ptr == LAST) ? '0 : wr_ptr + 1'b1;
      end
      if (rd_en) rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + 1'b1;
      if (wr_en & ~rd_en)      count <= count + 1'b1;
      else if (rd_en & ~wr_en) count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/fpu_add_issue_ctrl.sv
// Issuer/collector for the single-precision FP adder.
// Handshakes: a transfer happens on a cycle where valid&ready are both high;
// valid, once raised, is not required to stay high and ready never depends
// combinationally on the partner's valid (op_ready) or ready (res_valid).
module fpu_add_issue_ctrl #(
  parameter int FP_W  = 32,
  parameter int TAG_W = 4,
  parameter int DEPTH = 2,
  parameter int LAT   = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             op_valid,
  output logic             op_ready,
  input  logic             op_sub,
  input  logic [2:0]       op_rm,
  input  logic [FP_W-1:0]  op_a,
  input  logic [FP_W-1:0]  op_b,
  input  logic [TAG_W-1:0] op_tag,
  input  logic [2:0]       frm,
  input  logic             drain_req,
  output logic             drain_done,
  output logic             fpu_req,
  output logic [2:0]       fpu_rm,
  output logic [FP_W-1:0]  fpu_a,
  output logic [FP_W-1:0]  fpu_b,
  input  logic             fpu_valid,
  input  logic [FP_W-1:0]  fpu_out,
  input  logic [2:0]       fpu_exc,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [FP_W-1:0]  res_data,
  output logic [TAG_W-1:0] res_tag,
  output logic [4:0]       res_fflags,
  output logic             res_illegal,
  output logic [4:0]       fflags_acc,
  input  logic             fflags_clr,
  output logic             proto_err,
  output logic [1:0]       dbg_state
);
  import fpu_pkg::*;

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int ENT_W = FP_W + TAG_W + 6;

  logic [1:0]       state;
  logic [2:0]       rm_eff;
  logic             legal;
  logic             accept;
  logic [LAT-1:0]   pipe_vld;
  logic [LAT-1:0]   pipe_legal;
  logic [TAG_W-1:0] pipe_tag [LAT];
  logic             out_vld;
  logic             out_legal;
  logic [CNT_W:0]   inflight;
  logic [CNT_W:0]   used;
  logic [CNT_W-1:0] fifo_count;
  logic             idle;
  logic [ENT_W-1:0] push_ent;
  logic [ENT_W-1:0] head;
  logic             pop;

  // Rounding resolution, credit check and combinational issue to the adder
  always_comb begin
    rm_eff   = (op_rm == RM_DYN) ? frm : op_rm;
    legal    = rm_is_legal(rm_eff);
    inflight = '0;
    for (int i = 0; i < LAT; i++) inflight = inflight + {{CNT_W{1'b0}}, pipe_vld[i]};
    used     = inflight + {1'b0, fifo_count};
    idle     = (used == '0);
    op_ready = rst & (state == ST_RUN) & (used < (CNT_W+1)'(DEPTH));
    accept   = op_valid & op_ready;
    fpu_req  = accept & legal;
    fpu_a    = rst ? op_a : '0;
    fpu_b    = rst ? {op_b[FP_W-1] ^ op_sub, op_b[FP_W-2:0]} : '0;
    fpu_rm   = rst ? rm_eff : 3'b000;
  end

  // Tag pipe mirrors the adder latency; it never stalls
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pipe_vld   <= '0;
      pipe_legal <= '0;
      for (int i = 0; i < LAT; i++) pipe_tag[i] <= '0;
    end else begin
      pipe_vld[0]   <= accept;
      pipe_legal[0] <= legal;
      pipe_tag[0]   <= op_tag;
      for (int i = 1; i < LAT; i++) begin
        pipe_vld[i]   <= pipe_vld[i-1];
        pipe_legal[i] <= pipe_legal[i-1];
        pipe_tag[i]   <= pipe_tag[i-1];
      end
    end
  end

  // Result entry assembled at the pipe output; illegal ops carry zeros
  always_comb begin
    out_vld   = pipe_vld[LAT-1];
    out_legal = pipe_legal[LAT-1];
    push_ent  = {(out_legal ? fpu_out : {FP_W{1'b0}}),
                 pipe_tag[LAT-1],
                 (out_legal ? exc_to_fflags(fpu_exc) : 5'b00000),
                 ~out_legal};
  end

  fpu_result_fifo #(
    .W     (ENT_W),
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (out_vld),
    .push_ent (push_ent),
    .pop      (res_ready),
    .valid    (res_valid),
    .head     (head),
    .count    (fifo_count)
  );

  // Unpack the FIFO head onto the result port
  always_comb begin
    res_data    = head[ENT_W-1 -: FP_W];
    res_tag     = head[TAG_W+5 : 6];
    res_fflags  = head[5:1];
    res_illegal = head[0];
    pop         = res_valid & res_ready;
    drain_done  = (state == ST_DRAIN) & idle;
    dbg_state   = state;
  end

  // Accrued flags and sticky adder protocol checker
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fflags_acc <= '0;
      proto_err  <= 1'b0;
    end else begin
      fflags_acc <= (fflags_clr ? 5'b00000 : fflags_acc) | (pop ? res_fflags : 5'b00000);
      if ((out_vld & out_legal & ~fpu_valid) | (fpu_valid & ~(out_vld & out_legal)))
        proto_err <= 1'b1;
    end
  end

  // Drain FSM: stop accepting, wait for empty, pulse done, optionally hold
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_RUN;
    end else begin
      case (state)
        ST_RUN:   if (drain_req) state <= ST_DRAIN;
        ST_DRAIN: if (idle) state <= drain_req ? ST_HOLD : ST_RUN;
        ST_HOLD:  if (!drain_req) state <= ST_RUN;
        default:  state <= ST_RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_fpu_add_issue_ctrl.sv
// Directed bench for fpu_add_issue_ctrl with a table-driven 1-cycle adder model.
module tb_fpu_add_issue_ctrl;

  logic        clk;
  logic        rst;
  logic        op_valid;
  logic        op_ready;
  logic        op_sub;
  logic [2:0]  op_rm;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic [3:0]  op_tag;
  logic [2:0]  frm;
  logic        drain_req;
  logic        drain_done;
  logic        fpu_req;
  logic [2:0]  fpu_rm;
  logic [31:0] fpu_a;
  logic [31:0] fpu_b;
  logic        fpu_valid;
  logic [31:0] fpu_out;
  logic [2:0]  fpu_exc;
  logic        res_valid;
  logic        res_ready;
  logic [31:0] res_data;
  logic [3:0]  res_tag;
  logic [4:0]  res_fflags;
  logic        res_illegal;
  logic [4:0]  fflags_acc;
  logic        fflags_clr;
  logic        proto_err;
  logic [1:0]  dbg_state;

  int total = 0;
  int bad   = 0;

  logic        mdl_v;
  logic        inj_v;

  fpu_add_issue_ctrl #(.FP_W(32), .TAG_W(4), .DEPTH(2), .LAT(1)) dut (
    .clk(clk), .rst(rst),
    .op_valid(op_valid), .op_ready(op_ready), .op_sub(op_sub), .op_rm(op_rm),
    .op_a(op_a), .op_b(op_b), .op_tag(op_tag), .frm(frm),
    .drain_req(drain_req), .drain_done(drain_done),
    .fpu_req(fpu_req), .fpu_rm(fpu_rm), .fpu_a(fpu_a), .fpu_b(fpu_b),
    .fpu_valid(fpu_valid), .fpu_out(fpu_out), .fpu_exc(fpu_exc),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_tag(res_tag), .res_fflags(res_fflags), .res_illegal(res_illegal),
    .fflags_acc(fflags_acc), .fflags_clr(fflags_clr), .proto_err(proto_err),
    .dbg_state(dbg_state)
  );

  // clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Adder stand-in: known sums for the operand pairs used below, {exc,out}
  function automatic logic [34:0] add_model(input logic [31:0] a, input logic [31:0] b);
    case ({a, b})
      {32'h3FA00000, 32'h3FB00000}: return {3'b111, 32'h40280000};
      {32'h3FA00000, 32'hBFC00000}: return {3'b111, 32'hBE800000};
      {32'h7F7FFFFF, 32'h7F7FFFFF}: return {3'b010, 32'h7F800000};
      {32'h3F800000, 32'h33800000}: return {3'b000, 32'h3F800000};
      {32'h3F800000, 32'h3F800000}: return {3'b111, 32'h40000000};
      {32'h40000000, 32'h40000000}: return {3'b111, 32'h40800000};
      {32'h40400000, 32'h40400000}: return {3'b111, 32'h40C00000};
      default:                      return {3'b100, 32'h7FC00000};
    endcase
  endfunction

  // adder model: result one cycle after the sampled request; its reset is ~rst of the adder
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      mdl_v   <= 1'b0;
      fpu_out <= '0;
      fpu_exc <= 3'b111;
    end else begin
      mdl_v <= fpu_req;
      {fpu_exc, fpu_out} <= add_model(fpu_a, fpu_b);
    end
  end
  assign fpu_valid = mdl_v | inj_v;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_op(input logic sub, input logic [2:0] rm, input logic [31:0] a,
                        input logic [31:0] b, input logic [3:0] tag);
    op_valid = 1'b1; op_sub = sub; op_rm = rm; op_a = a; op_b = b; op_tag = tag;
  endtask

  // watchdog
  initial begin
    #100000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b0; op_valid = 1'b1; op_sub = 1'b0; op_rm = 3'b000; op_tag = 4'd0;
    op_a = 32'h3FA00000; op_b = 32'h3FB00000; frm = 3'b000; drain_req = 1'b0;
    res_ready = 1'b0; fflags_clr = 1'b0; inj_v = 1'b0;

    // reset: outputs zero even with an op offered
    tick(); tick();
    chk("rst_op_ready", op_ready, 0);
    chk("rst_fpu_req", fpu_req, 0);
    chk("rst_fpu_a", fpu_a, 0);
    chk("rst_fpu_b", fpu_b, 0);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_res_data", res_data, 0);
    chk("rst_acc", fflags_acc, 0);
    chk("rst_proto", proto_err, 0);
    chk("rst_drain_done", drain_done, 0);
    op_valid = 1'b0; rst = 1'b1; #1;
    chk("run_op_ready", op_ready, 1);

    // FADD 1.25 + 1.375 = 2.625, result one cycle after issue, held while stalled
    set_op(1'b0, 3'b000, 32'h3FA00000, 32'h3FB00000, 4'd3); #1;
    chk("add_fpu_req", fpu_req, 1);
    chk("add_fpu_b", fpu_b, 32'h3FB00000);
    chk("add_fpu_rm", fpu_rm, 0);
    tick(); op_valid = 1'b0; #1;
    chk("add_res_valid", res_valid, 1);
    chk("add_res_data", res_data, 32'h40280000);
    chk("add_res_tag", res_tag, 3);
    chk("add_res_fflags", res_fflags, 0);
    tick();
    chk("add_hold_valid", res_valid, 1);
    chk("add_hold_data", res_data, 32'h40280000);
    res_ready = 1'b1;
    tick(); res_ready = 1'b0; #1;
    chk("add_popped", res_valid, 0);
    chk("add_acc", fflags_acc, 0);

    // FSUB 1.25 - 1.5 = -0.25, B sign flipped at the adder
    set_op(1'b1, 3'b001, 32'h3FA00000, 32'h3FC00000, 4'd4); #1;
    chk("sub_fpu_b", fpu_b, 32'hBFC00000);
    chk("sub_fpu_rm", fpu_rm, 1);
    tick(); op_valid = 1'b0; op_sub = 1'b0; res_ready = 1'b1; #1;
    chk("sub_res_data", res_data, 32'hBE800000);
    chk("sub_res_tag", res_tag, 4);
    tick(); res_ready = 1'b0;

    // overflow -> OF|NX, then clear accrued flags while popping an NX result
    set_op(1'b0, 3'b000, 32'h7F7FFFFF, 32'h7F7FFFFF, 4'd1);
    tick(); op_valid = 1'b0; res_ready = 1'b1; #1;
    chk("of_res_data", res_data, 32'h7F800000);
    chk("of_res_fflags", res_fflags, 5'b00101);
    tick(); res_ready = 1'b0; #1;
    chk("of_acc", fflags_acc, 5'b00101);
    set_op(1'b0, 3'b000, 32'h3F800000, 32'h33800000, 4'd2);
    tick(); op_valid = 1'b0; res_ready = 1'b1; fflags_clr = 1'b1; #1;
    chk("nx_res_fflags", res_fflags, 5'b00001);
    tick(); res_ready = 1'b0; fflags_clr = 1'b0; #1;
    chk("clr_pop_acc", fflags_acc, 5'b00001);

    // illegal dynamic rm between two legal ops, streaming with res_ready=1
    res_ready = 1'b1;
    set_op(1'b0, 3'b000, 32'h3F800000, 32'h3F800000, 4'd5); #1;
    chk("ill_first_req", fpu_req, 1);
    tick();
    set_op(1'b0, 3'b111, 32'h40000000, 32'h40000000, 4'd6); frm = 3'b101; #1;
    chk("ill_op_ready", op_ready, 1);
    chk("ill_no_req", fpu_req, 0);
    chk("ill_fpu_rm", fpu_rm, 5);
    chk("ill_prev_tag", res_tag, 5);
    chk("ill_prev_data", res_data, 32'h40000000);
    tick();
    set_op(1'b0, 3'b000, 32'h40000000, 32'h40000000, 4'd7); #1;
    chk("ill_next_req", fpu_req, 1);
    chk("ill_flag", res_illegal, 1);
    chk("ill_data", res_data, 0);
    chk("ill_tag", res_tag, 6);
    chk("ill_fflags", res_fflags, 0);
    tick(); op_valid = 1'b0; #1;
    chk("ill_after_tag", res_tag, 7);
    chk("ill_after_data", res_data, 32'h40800000);
    chk("ill_after_flag", res_illegal, 0);
    tick(); res_ready = 1'b0; frm = 3'b000; #1;
    chk("ill_proto", proto_err, 0);
    chk("ill_empty", res_valid, 0);

    // credit limit: 3 ops offered with res_ready=0, DEPTH=2
    set_op(1'b0, 3'b000, 32'h3F800000, 32'h3F800000, 4'd8);
    tick();
    set_op(1'b0, 3'b000, 32'h40000000, 32'h40000000, 4'd9); #1;
    chk("cr_second_ready", op_ready, 1);
    tick();
    set_op(1'b0, 3'b000, 32'h40400000, 32'h40400000, 4'd10); #1;
    chk("cr_full_ready", op_ready, 0);
    tick();
    chk("cr_still_full", op_ready, 0);
    res_ready = 1'b1; #1;
    chk("cr_pop_no_comb", op_ready, 0);
    chk("cr_head8", res_tag, 8);
    tick(); res_ready = 1'b0; #1;
    chk("cr_third_ready", op_ready, 1);
    chk("cr_third_req", fpu_req, 1);
    tick(); op_valid = 1'b0; #1;
    chk("cr_head9", res_tag, 9);
    res_ready = 1'b1;
    tick();
    chk("cr_head10", res_tag, 10);
    chk("cr_data10", res_data, 32'h40C00000);
    tick(); res_ready = 1'b0; #1;
    chk("cr_empty", res_valid, 0);

    // drain with two results buffered
    set_op(1'b0, 3'b000, 32'h3F800000, 32'h3F800000, 4'd11);
    tick();
    set_op(1'b0, 3'b000, 32'h40000000, 32'h40000000, 4'd12);
    tick(); op_valid = 1'b0; drain_req = 1'b1; #1;
    chk("dr_not_done", drain_done, 0);
    tick();
    chk("dr_op_ready", op_ready, 0);
    chk("dr_wait", drain_done, 0);
    chk("dr_head11", res_tag, 11);
    res_ready = 1'b1;
    tick();
    chk("dr_head12", res_tag, 12);
    chk("dr_wait2", drain_done, 0);
    tick(); res_ready = 1'b0; #1;
    chk("dr_done", drain_done, 1);
    chk("dr_empty", res_valid, 0);
    tick();
    chk("dr_pulse_end", drain_done, 0);
    chk("dr_hold_ready", op_ready, 0);
    drain_req = 1'b0;
    tick();
    chk("dr_back_run", op_ready, 1);

    // drain with nothing pending
    drain_req = 1'b1;
    tick();
    chk("dr0_done", drain_done, 1);
    drain_req = 1'b0;
    tick();
    chk("dr0_pulse_end", drain_done, 0);
    chk("dr0_ready", op_ready, 1);

    // reset mid-flight, adder valid arriving late is ignored
    set_op(1'b0, 3'b000, 32'h3F800000, 32'h3F800000, 4'd13);
    tick(); op_valid = 1'b0; #1;
    chk("mr_res_valid", res_valid, 1);
    rst = 1'b0; #1;
    chk("mr_rst_valid", res_valid, 0);
    chk("mr_rst_data", res_data, 0);
    chk("mr_rst_tag", res_tag, 0);
    chk("mr_rst_ready", op_ready, 0);
    chk("mr_rst_acc", fflags_acc, 0);
    inj_v = 1'b1;
    tick(); tick();
    inj_v = 1'b0; rst = 1'b1; #1;
    chk("mr_proto", proto_err, 0);
    chk("mr_no_result", res_valid, 0);

    // stray adder valid with nothing pending sets sticky proto_err
    inj_v = 1'b1; #1;
    chk("pe_before", proto_err, 0);
    tick(); inj_v = 1'b0; #1;
    chk("pe_set", proto_err, 1);
    tick();
    chk("pe_sticky", proto_err, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
